// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer.
//  - default widths / ratio / flush delay
//  - lane_t: lane index sized for the default ratio
//  - lanes_to_keep(n): mask with the n lowest lanes set (partial-word keep)
package fifo_pkg;

    localparam int unsigned DSIZE_DEF        = 8;
    localparam int unsigned RATIO_DEF        = 4;
    localparam int unsigned FLUSH_CYCLES_DEF = 16;
    localparam int unsigned MAX_RATIO        = 32;

    typedef logic [$clog2(RATIO_DEF)-1:0] lane_t;

    function automatic logic [MAX_RATIO-1:0] lanes_to_keep(input int unsigned n);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bus bundle between the async FIFO read port, the packer and the packed-word consumer.
//  FIFO side  : rdata, rempty (into packer), rinc (pop strobe out of packer)
//  Stream side: out_data, out_keep, out_valid (out of packer), out_ready (into packer)
// Handshake: a packed word transfers on every rising clock edge where
// out_valid && out_ready; while out_valid && !out_ready the producer holds
// out_data/out_keep/out_valid stable. A FIFO word is consumed on every edge
// where rinc=1, and rinc is only raised while rempty=0 (rdata is the head word).
// Modports: slave = packer view, master = environment (FIFO + consumer) view.
interface fifo_rd_packer_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned RATIO = 4
);
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic [DSIZE*RATIO-1:0] out_data;
    logic [RATIO-1:0]       out_keep;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  rdata, rempty, out_ready,
        output rinc, out_data, out_keep, out_valid
    );

    modport master (
        output rdata, rempty, out_ready,
        input  rinc, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_flush_timer.sv
// Idle timer for partial-word flushing.
// Counts consecutive cycles in which a partial word is pending and the FIFO is
// empty; any pop or leaving that condition clears it. The count saturates at
// FLUSH_CYCLES, and flush_due stays high until the partial word is taken.
// Ports: clk, rst (sync, active-high), active (partial pending && empty),
//        pop (FIFO pop this cycle), flush_due (threshold reached).
module fifo_flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic pop,
    output logic flush_due
);
    localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(FLUSH_CYCLES);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || pop || !active) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + TW'(1);
        end
    end

    assign flush_due = (count == LIMIT);
endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops the async FIFO (first-word fall-through) and packs
// RATIO consecutive DSIZE words into one registered valid/ready output word,
// first popped word in the lowest lane. Sustains one pop per cycle.
// Ports: rclk (only clock), rrst (sync, active-high), bus (fifo_rd_packer_if.slave:
//        rdata/rempty/rinc FIFO port, out_data/out_keep/out_valid/out_ready stream).
// Build option: FIFO_PACK_FLUSH_EN adds a flush of partial words after
//        FLUSH_CYCLES idle cycles (fifo_flush_timer); without it partial words wait.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE        = DSIZE_DEF,
    parameter int unsigned RATIO        = RATIO_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic rclk,
    input  logic rrst,
    fifo_rd_packer_if.slave bus
);
    localparam int unsigned CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if (RATIO < 2 || RATIO > MAX_RATIO || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("fifo_rd_packer: RATIO must be a power of 2 in [2, MAX_RATIO]");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("fifo_rd_packer: FLUSH_CYCLES must be >= 1");
    end

    logic [CW-1:0]              cnt;
    logic [DSIZE*(RATIO-1)-1:0] acc;      // lanes 0..RATIO-2 of the word being built
    logic [DSIZE*RATIO-1:0]     data_q;
    logic [RATIO-1:0]           keep_q;
    logic                       valid_q;

    logic last_lane;
    logic out_free;
    logic pop;
    logic load_full;
    logic load_flush;

    assign last_lane = (cnt == LAST);
    assign out_free  = !valid_q || bus.out_ready;
    // Only the last lane needs room in the output register; earlier lanes
    // land in the accumulator, so a stalled consumer never starves them.
    assign pop       = !bus.rempty && !rrst && (!last_lane || out_free);
    assign load_full = pop && last_lane;

`ifdef FIFO_PACK_FLUSH_EN
    logic flush_due;
    logic flush_active;

    assign flush_active = (cnt != '0) && bus.rempty;

    fifo_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk      (rclk),
        .rst      (rrst),
        .active   (flush_active),
        .pop      (pop),
        .flush_due(flush_due)
    );

    // A pop in the same cycle takes priority; the timer clears on it.
    assign load_flush = flush_due && !pop && out_free && (cnt != '0);
`else
    assign load_flush = 1'b0;
`endif

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt     <= '0;
            acc     <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // Clearing acc on every word boundary keeps unused lanes of a
            // flushed partial word at zero.
            if (load_full || load_flush) begin
                cnt <= '0;
                acc <= '0;
            end else if (pop) begin
                cnt <= cnt + CW'(1);
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (cnt == CW'(i)) acc[i*DSIZE +: DSIZE] <= bus.rdata;
                end
            end

            if (load_full) begin
                data_q  <= {bus.rdata, acc};
                keep_q  <= '1;
                valid_q <= 1'b1;
            end else if (load_flush) begin
                data_q  <= {{DSIZE{1'b0}}, acc};
                keep_q  <= RATIO'(lanes_to_keep(32'(cnt)));
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rinc      = pop;
    assign bus.out_data  = data_q;
    assign bus.out_keep  = keep_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer (DSIZE=8, RATIO=4, FLUSH_CYCLES=16).
// A FIFO model (feed_q) drives rdata/rempty; a packing model groups every four
// popped words into an expected beat (exp_q); accepted beats are compared in order.
module tb_fifo_rd_packer;
    localparam int unsigned DSIZE = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned DW    = DSIZE * RATIO;
    localparam int unsigned W     = DW + RATIO;

    // ---------------- clock / reset ----------------
    logic rclk = 1'b0;
    logic rrst;
    always #5 rclk = ~rclk;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus ();

    fifo_rd_packer #(
        .DSIZE(DSIZE),
        .RATIO(RATIO),
        .FLUSH_CYCLES(16)
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .bus (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] feed_q[$];   // words waiting in the modelled FIFO
    logic [DSIZE-1:0] part_q[$];   // popped words not yet forming a full beat
    logic [W-1:0]     exp_q[$];    // expected beats {keep, data}

    int  ready_mode = 1;           // 0: low, 1: high, 2: random
    int  empty_pct  = 0;           // chance of an artificial empty cycle
    bit  rst_req    = 1'b1;
    int  rinc_cnt   = 0;
    int  beat_cnt   = 0;
    int  rinc_run   = 0;
    int  max_run    = 0;
    int  idle_run   = 0;
    logic [DW-1:0]    last_data = '0;
    logic [RATIO-1:0] last_keep = '0;
    bit               prev_stall = 1'b0;
    logic [DW-1:0]    prev_data;
    logic [RATIO-1:0] prev_keep;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver + monitor (one step per cycle) ----------------
    always @(negedge rclk) begin
        bit gate;
        rrst = rst_req;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 99) < 70);
        endcase
        // Artificial empty runs are capped below the flush delay.
        gate = (feed_q.size() == 0) ||
               (idle_run < 8 && $urandom_range(0, 99) < empty_pct);
        bus.rempty = gate;
        bus.rdata  = gate ? DSIZE'($urandom) : feed_q[0];
        idle_run   = gate ? idle_run + 1 : 0;
        #2;
        if (bus.rempty) check("rinc_while_empty", 64'(bus.rinc), 64'd0);
        if (rrst) begin
            check("rinc_in_reset", 64'(bus.rinc), 64'd0);
            part_q.delete();
            exp_q.delete();
            rinc_run   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
                check("hold_keep", 64'(bus.out_keep), 64'(prev_keep));
            end
            if (bus.rinc && feed_q.size() > 0) begin
                part_q.push_back(feed_q.pop_front());
                rinc_cnt++;
                rinc_run++;
                if (rinc_run > max_run) max_run = rinc_run;
                if (part_q.size() == RATIO) begin
                    exp_q.push_back({4'hF, part_q[3], part_q[2], part_q[1], part_q[0]});
                    part_q.delete();
                end
            end else begin
                rinc_run = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_cnt++;
                last_data = bus.out_data;
                last_keep = bus.out_keep;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h/%h expected no beat", bus.out_keep, bus.out_data);
                end else begin
                    check("beat", 64'({bus.out_keep, bus.out_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_keep  = bus.out_keep;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge rclk);
    endtask

    task automatic push_word(input logic [DSIZE-1:0] w);
        feed_q.push_back(w);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((feed_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            @(posedge rclk);
            k++;
        end
        check({name, "_timeout"}, 64'(k < budget), 64'd1);
        cycles(2);
    endtask

    task automatic pulse_reset();
        rst_req = 1'b1;
        @(posedge rclk);
        @(negedge rclk);
        #3;
        check("valid_in_reset", 64'(bus.out_valid), 64'd0);
        rst_req = 1'b0;
        @(posedge rclk);
        #1;
        check("valid_after_reset", 64'(bus.out_valid), 64'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [DSIZE-1:0] w [RATIO];
        logic [DW-1:0]    exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : test
        int r0, b0, k;

        vecs[0].w = '{8'h11, 8'h22, 8'h33, 8'h44}; vecs[0].exp_data = 32'h44332211;
        vecs[1].w = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].exp_data = 32'h00000000;
        vecs[2].w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[2].exp_data = 32'hFFFFFFFF;
        vecs[3].w = '{8'h01, 8'h80, 8'h7F, 8'hFE}; vecs[3].exp_data = 32'hFE7F8001;
        vecs[4].w = '{8'hA5, 8'h5A, 8'hC3, 8'h3C}; vecs[4].exp_data = 32'h3CC35AA5;

        rrst          = 1'b1;
        bus.rempty    = 1'b1;
        bus.rdata     = '0;
        bus.out_ready = 1'b0;

        // reset state
        cycles(3);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_keep", 64'(bus.out_keep), 64'd0);
        rst_req = 1'b0;
        cycles(2);

        // single-beat vectors with latency check
        for (int v = 0; v < 5; v++) begin
            r0 = rinc_cnt;
            b0 = beat_cnt;
            for (int i = 0; i < RATIO; i++) push_word(vecs[v].w[i]);
            k = 0;
            while (feed_q.size() != 0 && k < 50) begin
                @(negedge rclk);
                #3;
                k++;
            end
            check("vec_pre_valid", 64'(bus.out_valid), 64'd0);
            @(posedge rclk);
            #1;
            check("vec_latency_valid", 64'(bus.out_valid), 64'd1);
            check("vec_data", 64'(bus.out_data), 64'(vecs[v].exp_data));
            wait_idle("vec", 50);
            check("vec_last_data", 64'(last_data), 64'(vecs[v].exp_data));
            check("vec_keep", 64'(last_keep), 64'hF);
            check("vec_rinc_pulses", 64'(rinc_cnt - r0), 64'd4);
            check("vec_beats", 64'(beat_cnt - b0), 64'd1);
        end

        // back-to-back eight words
        max_run = 0;
        b0 = beat_cnt;
        for (int i = 1; i <= 8; i++) push_word(DSIZE'(8'h11 * i));
        wait_idle("b2b", 50);
        check("b2b_rinc_run", 64'(max_run), 64'd8);
        check("b2b_beats", 64'(beat_cnt - b0), 64'd2);
        check("b2b_last", 64'(last_data), 64'h88776655);

        // stalled consumer
        ready_mode = 0;
        b0 = beat_cnt;
        for (int i = 1; i <= 8; i++) push_word(DSIZE'(8'h11 * i));
        cycles(15);
        #1;
        check("stall_left_in_fifo", 64'(feed_q.size()), 64'd1);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_data", 64'(bus.out_data), 64'h44332211);
        ready_mode = 1;
        wait_idle("stall", 50);
        check("stall_beats", 64'(beat_cnt - b0), 64'd2);
        check("stall_last", 64'(last_data), 64'h88776655);

        // reset mid-word
        push_word(8'hAA);
        push_word(8'hBB);
        cycles(4);
        pulse_reset();
        b0 = beat_cnt;
        for (int i = 1; i <= 4; i++) push_word(DSIZE'(i));
        wait_idle("rstmid", 50);
        check("rstmid_beats", 64'(beat_cnt - b0), 64'd1);
        check("rstmid_data", 64'(last_data), 64'h04030201);

        // partial word then idle
        b0 = beat_cnt;
        push_word(8'hAA);
        push_word(8'hBB);
        cycles(4);
`ifdef FIFO_PACK_FLUSH_EN
        part_q.delete();
        exp_q.push_back({4'h3, 32'h0000BBAA});
        k = 0;
        while (beat_cnt == b0 && k < 60) begin
            @(posedge rclk);
            k++;
        end
        check("flush_timeout", 64'(k < 60), 64'd1);
        check("flush_wait_min", 64'(k >= 12), 64'd1);
        cycles(2);
        check("flush_data", 64'(last_data), 64'h0000BBAA);
        check("flush_keep", 64'(last_keep), 64'h3);
`else
        cycles(40);
        #1;
        check("noflush_beats", 64'(beat_cnt - b0), 64'd0);
        check("noflush_valid", 64'(bus.out_valid), 64'd0);
        pulse_reset();
`endif

        // random traffic
        ready_mode = 2;
        empty_pct  = 30;
        r0 = rinc_cnt;
        b0 = beat_cnt;
        for (int i = 0; i < 10000; i++) push_word(DSIZE'($urandom));
        wait_idle("rand", 60000);
        check("rand_pops", 64'(rinc_cnt - r0), 64'd10000);
        check("rand_beats", 64'(beat_cnt - b0), 64'd2500);
        check("rand_partial_left", 64'(part_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
